// File: rtl/cpu_controller.sv
// Eight-phase sequencer for a simple accumulator CPU: decodes phase, opcode and the
// zero flag into datapath control strobes, and latches a halted state on HLT.
module cpu_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    StInstAddr  = 3'd0,
    StInstFetch = 3'd1,
    StInstLoad  = 3'd2,
    StIdle      = 3'd3,
    StOpAddr    = 3'd4,
    StOpFetch   = 3'd5,
    StAluOp     = 3'd6,
    StStore     = 3'd7
  } phase_e;

  localparam logic [2:0] OpHlt = 3'b000;
  localparam logic [2:0] OpSkz = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpLda = 3'b101;
  localparam logic [2:0] OpSto = 3'b110;
  localparam logic [2:0] OpJmp = 3'b111;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   alu_op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= StInstAddr;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Once halted, phase freezes at OP_ADDR until reset.
  always_comb begin
    phase_d  = phase_e'(phase_q + 3'd1);
    halted_d = halted_q;
    if (halted_q) begin
      phase_d = phase_q;
    end else if (phase_q == StOpAddr && opcode == OpHlt) begin
      phase_d  = StOpAddr;
      halted_d = 1'b1;
    end
  end

  assign alu_op = (opcode == OpAdd) || (opcode == OpAnd) || (opcode == OpXor) ||
                  (opcode == OpLda);
  assign phase  = phase_q;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    // Reset overrides everything so an aborted instruction emits no strobes.
    if (!rst_n) begin
      sel = 1'b1;
    end else if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        StInstAddr: begin
          sel = 1'b1;
        end
        StInstFetch: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        StInstLoad, StIdle: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        StOpAddr: begin
          inc_pc = 1'b1;
          halt   = (opcode == OpHlt);
        end
        StOpFetch: begin
          rd = alu_op;
        end
        StAluOp: begin
          rd     = alu_op;
          inc_pc = (opcode == OpSkz) && zero;
          ld_pc  = (opcode == OpJmp);
          data_e = (opcode == OpSto);
        end
        StStore: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OpJmp);
          wr     = (opcode == OpSto);
          data_e = (opcode == OpSto);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: expected phase/control vectors are queued as each cycle
// is driven and popped for comparison half a clock later.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  cpu_controller dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [8:0] ctrl; // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         pass_cnt = 0;
  logic [2:0] m_phase;
  logic       m_halted;

  function automatic logic [8:0] exp_ctrl(logic [2:0] ph, logic [2:0] op, logic z,
                                          logic hlt, logic r);
    logic aluop;
    aluop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    if (!r) return 9'b1_0000_0000;
    if (hlt) return 9'b0_0000_0001;
    case (ph)
      3'd0:    return 9'b1_0000_0000;
      3'd1:    return 9'b1_1000_0000;
      3'd2,
      3'd3:    return 9'b1_1100_0000;
      3'd4:    return {4'b0001, 4'b0000, op == 3'd0};
      3'd5:    return {1'b0, aluop, 7'b0};
      3'd6:    return {1'b0, aluop, 1'b0, (op == 3'd1) && z, op == 3'd7, 2'b00, op == 3'd6, 1'b0};
      default: return {1'b0, aluop, 2'b00, op == 3'd7, aluop, op == 3'd6, op == 3'd6, 1'b0};
    endcase
  endfunction

  // Drive one cycle, queue its expectation, compare at negedge, then advance the model.
  task automatic cycle(input logic [2:0] op, input logic z, input logic r, input string tag);
    exp_t e;
    exp_t got;
    opcode = op;
    zero   = z;
    rst_n  = r;
    sb_q.push_back('{ph: m_phase, ctrl: exp_ctrl(m_phase, op, z, m_halted, r)});
    @(negedge clk);
    got = '{ph: phase, ctrl: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}};
    e   = sb_q.pop_front();
    checks++;
    assert (got.ph === e.ph) pass_cnt++;
    else $error("FAIL %s phase: got %0d expected %0d", tag, got.ph, e.ph);
    checks++;
    assert (got.ctrl === e.ctrl) pass_cnt++;
    else $error("FAIL %s ctrl@ph%0d: got %b expected %b", tag, e.ph, got.ctrl, e.ctrl);
    @(posedge clk);
    if (!r) begin
      m_phase  = 3'd0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_phase == 3'd4 && op == 3'd0) m_halted = 1'b1;
      else m_phase = m_phase + 3'd1;
    end
    #1;
  endtask

  task automatic instr(input logic [2:0] op, input logic z, input string tag);
    for (int i = 0; i < 8; i++) cycle(op, z, 1'b1, tag);
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 3'd0;
    zero   = 1'b0;
    @(posedge clk);
    #1;
    m_phase  = 3'd0;
    m_halted = 1'b0;

    cycle(3'd2, 1'b0, 1'b0, "reset_hold");
    instr(3'd2, 1'b0, "add");
    instr(3'd6, 1'b1, "sto");
    instr(3'd1, 1'b1, "skz_z1");
    instr(3'd1, 1'b0, "skz_z0");
    instr(3'd7, 1'b0, "jmp");
    instr(3'd3, 1'b1, "and");
    instr(3'd4, 1'b0, "xor");
    instr(3'd5, 1'b1, "lda");
    for (int i = 0; i < 8; i++) cycle(3'($urandom_range(1, 7)), 1'($urandom), 1'b1, "rand");

    // Abort a store at ALU_OP with reset.
    for (int i = 0; i < 6; i++) cycle(3'd6, 1'b0, 1'b1, "sto_pre");
    cycle(3'd6, 1'b0, 1'b0, "sto_abort");
    instr(3'd6, 1'b0, "sto_resume");

    // Halt, then confirm inputs are ignored until reset.
    for (int i = 0; i < 5; i++) cycle(3'd0, 1'b0, 1'b1, "hlt");
    for (int i = 0; i < 22; i++)
      cycle(3'($urandom_range(0, 7)), 1'($urandom), 1'b1, "halted");
    cycle(3'd2, 1'b1, 1'b0, "hlt_reset");
    instr(3'd2, 1'b0, "add_after_halt");

    if (sb_q.size() != 0) $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    $display("%0d/%0d checks passed", pass_cnt, checks);
    $finish;
  end

endmodule
